// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the single-port memory arbiter:
//   - read tag encoding (which core channel owns an outstanding read)
//   - grant select encoding used by the arbitration logic
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Owner of an outstanding read, stored in the in-order tag queue.
  localparam logic TAG_FETCH = 1'b0;
  localparam logic TAG_DATA  = 1'b1;

  // Which channel, if any, drives the memory request this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2,
    GNT_IF   = 2'd3
  } gnt_e;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_tag_fifo.sv
// -----------------------------------------------------------------------------
// tag_fifo
// Small synchronous FIFO, 1 bit wide, holding the owner tag of every read that
// memory has accepted but not yet answered. The head is presented
// combinationally so a response can be routed in the same cycle it arrives.
//
// Ports:
//   clk     in   clock
//   resetb  in   synchronous active-low reset (clears pointers and count)
//   push    in   write din at the tail (caller guarantees not full)
//   pop     in   drop the head entry (caller guarantees not empty)
//   din     in   tag to push
//   dout    out  tag at the head
//   count   out  number of stored tags, $clog2(DEPTH)+1 bits
//   full    out  count == DEPTH
//   empty   out  count == 0
// -----------------------------------------------------------------------------
module tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     din,
  output logic                     dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int CW = $clog2(DEPTH) + 1;
  // A depth of 1 still needs a 1-bit pointer; it simply never leaves 0.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  logic          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage has no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head read is asynchronous on purpose: response routing adds no latency.
  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == COUNT_MAX);
  assign empty = (r_count == '0);

endmodule : tag_fifo

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between a core's instruction-fetch, data-read
// and data-write channels. At most one transfer is granted per cycle
// (write > data read > fetch, except when a waiting fetch has been passed over
// STARVE_LIMIT times in a row). Outstanding reads are tracked with an in-order
// tag queue so each response is routed back to the channel that issued it.
//
// Ports:
//   clk, resetb                      clock, synchronous active-low reset
//   imem_ready/valid/addr            fetch request / accept / address
//   imem_rresp/rdata                 fetch response
//   dmem_rready/rvalid/raddr         load request / accept / address
//   dmem_rresp/rdata                 load response
//   dmem_wready/wvalid/waddr/wdata/wstrb   store request / accept / payload
//   mem_ready/valid                  memory request / memory accepts
//   mem_we/addr/wdata/wstrb          memory request payload
//   mem_rresp/rdata                  in-order memory read response
//   err_unexp                        sticky: response with no read outstanding
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          imem_ready,
  output logic          imem_valid,
  input  logic [AW-1:0] imem_addr,
  output logic          imem_rresp,
  output logic [31:0]   imem_rdata,
  input  logic          dmem_rready,
  output logic          dmem_rvalid,
  input  logic [AW-1:0] dmem_raddr,
  output logic          dmem_rresp,
  output logic [31:0]   dmem_rdata,
  input  logic          dmem_wready,
  output logic          dmem_wvalid,
  input  logic [AW-1:0] dmem_waddr,
  input  logic [31:0]   dmem_wdata,
  input  logic [3:0]    dmem_wstrb,
  output logic          mem_ready,
  input  logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_rresp,
  input  logic [31:0]   mem_rdata,
  output logic          err_unexp
);

  import mem_arbiter_pkg::*;

  localparam int CW  = $clog2(OUTSTANDING) + 1;
  localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0]  TAG_MAX    = CW'(OUTSTANDING);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  logic [CW-1:0]  w_tag_count;
  logic           w_tag_full;
  logic           w_tag_empty;
  logic           w_tag_head;
  logic           w_push;
  logic           w_push_tag;
  logic           w_pop;
  logic           w_accept;
  logic           w_rd_room;
  logic           w_wr_elig;
  logic           w_rd_elig;
  logic           w_if_elig;
  logic           w_starved;
  gnt_e           w_gnt;
  logic [SCW-1:0] r_starve_cnt;
  logic           r_err_unexp;

  // full duplicates the count compare below; kept on the FIFO for reuse.
  logic w_unused_full;
  assign w_unused_full = w_tag_full;

  // ---------------------------------------------------------------------------
  // Eligibility and grant. Read room is judged on the registered count only,
  // so a response popping this cycle cannot open a slot (no rresp->ready path).
  // ---------------------------------------------------------------------------
  assign w_rd_room = (w_tag_count < TAG_MAX);
  assign w_wr_elig = dmem_wready;
  assign w_rd_elig = dmem_rready && w_rd_room;
  assign w_if_elig = imem_ready && w_rd_room;
  assign w_starved = (STARVE_LIMIT != 0) && (r_starve_cnt == STARVE_MAX) && w_if_elig;

  always_comb begin
    w_gnt = GNT_NONE;
    if (!resetb) begin
      w_gnt = GNT_NONE;
    end else if (w_starved) begin
      w_gnt = GNT_IF;
    end else if (w_wr_elig) begin
      w_gnt = GNT_WR;
    end else if (w_rd_elig) begin
      w_gnt = GNT_RD;
    end else if (w_if_elig) begin
      w_gnt = GNT_IF;
    end
  end

  assign mem_ready = (w_gnt != GNT_NONE);
  assign w_accept  = mem_ready && mem_valid;

  always_comb begin
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    imem_valid  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_wvalid = 1'b0;
    w_push      = 1'b0;
    w_push_tag  = TAG_FETCH;
    case (w_gnt)
      GNT_WR: begin
        mem_we      = 1'b1;
        mem_addr    = dmem_waddr;
        mem_wdata   = dmem_wdata;
        mem_wstrb   = dmem_wstrb;
        dmem_wvalid = mem_valid;
      end
      GNT_RD: begin
        mem_addr    = dmem_raddr;
        dmem_rvalid = mem_valid;
        w_push      = mem_valid;
        w_push_tag  = TAG_DATA;
      end
      GNT_IF: begin
        mem_addr    = imem_addr;
        imem_valid  = mem_valid;
        w_push      = mem_valid;
        w_push_tag  = TAG_FETCH;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response routing: pop only with a live entry; responses during reset or
  // with an empty queue are dropped (the latter flags err_unexp).
  // ---------------------------------------------------------------------------
  assign w_pop      = resetb && mem_rresp && !w_tag_empty;
  assign imem_rresp = w_pop && (w_tag_head == TAG_FETCH);
  assign dmem_rresp = w_pop && (w_tag_head == TAG_DATA);
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
  assign err_unexp  = r_err_unexp;

  tag_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .clk    (clk),
    .resetb (resetb),
    .push   (w_push),
    .pop    (w_pop),
    .din    (w_push_tag),
    .dout   (w_tag_head),
    .count  (w_tag_count),
    .full   (w_tag_full),
    .empty  (w_tag_empty)
  );

  // Counts consecutive data transfers taken while a fetch is waiting.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_starve_cnt <= '0;
    end else if (!imem_ready) begin
      r_starve_cnt <= '0;
    end else if (w_accept && (w_gnt == GNT_IF)) begin
      r_starve_cnt <= '0;
    end else if (w_accept && ((w_gnt == GNT_WR) || (w_gnt == GNT_RD)) &&
                 (r_starve_cnt != STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_err_unexp <= 1'b0;
    end else if (mem_rresp && w_tag_empty) begin
      r_err_unexp <= 1'b1;
    end
  end

endmodule : mem_arbiter
